// File: rtl/elevator_scan_ctrl.sv
// Elevator core: per-floor pending bitmap, LOOK sweep scheduling, door dwell timer and fault alarm.
// Latency: a request is captured at the next edge; the motor or door command follows one edge later.
// Backpressure: none; one request per cycle is always taken, and out-of-range floors are dropped with a pulse.
module elevator_scan_ctrl #(
  parameter int pFLOOR_COUNT = 16,
  parameter int pFLOOR_WIDTH = 4,
  parameter int pDOOR_CYCLES = 32,
  parameter int pTIMER_BITS  = 6
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_req_valid,
  input  logic [pFLOOR_WIDTH-1:0] i_req_floor,
  input  logic [pFLOOR_WIDTH-1:0] i_current_floor,
  input  logic                    i_error_flag,
  input  logic                    i_error_clear,
  output logic                    o_move_up,
  output logic                    o_move_down,
  output logic                    o_open_door,
  output logic                    o_alarm,
  output logic                    o_dir_up,
  output logic [pFLOOR_COUNT-1:0] o_pending,
  output logic                    o_req_drop
);

  // Every encodable floor index gets a validity bit, so both floor inputs can index it directly.
  localparam int LP_SLOTS = 1 << pFLOOR_WIDTH;
  localparam logic [LP_SLOTS-1:0] LP_VALID = {LP_SLOTS{1'b1}} >> (LP_SLOTS - pFLOOR_COUNT);
  localparam logic [pTIMER_BITS-1:0] LP_DOOR_LAST = pTIMER_BITS'(pDOOR_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE_UP,
    ST_MOVE_DOWN,
    ST_DOOR_OPEN,
    ST_ALARM
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_dir_up;
  logic                    w_dir_nxt;
  logic [pTIMER_BITS-1:0]  r_timer;
  logic [pTIMER_BITS-1:0]  w_timer_nxt;
  logic [pFLOOR_COUNT-1:0] r_pending;
  logic [pFLOOR_COUNT-1:0] w_pending_nxt;
  logic                    r_req_drop;
  logic                    w_fault;
  logic                    w_req_in_range;
  logic                    w_hold;
  logic                    w_clear_cur;
  logic                    w_pend_cur;
  logic                    w_above;
  logic                    w_below;

  // A sensor reading outside the served floors is as bad as an explicit fault.
  assign w_fault        = i_error_flag | ~LP_VALID[i_current_floor];
  assign w_req_in_range = LP_VALID[i_req_floor];
  // A call for the floor the door is open at extends the dwell instead of queuing a stop.
  assign w_hold         = (r_state == ST_DOOR_OPEN) && i_req_valid && (i_req_floor == i_current_floor);

  // Locate pending requests relative to the car.
  always_comb begin
    w_pend_cur = 1'b0;
    w_above    = 1'b0;
    w_below    = 1'b0;
    for (int k = 0; k < pFLOOR_COUNT; k++) begin
      if (r_pending[k]) begin
        if (k == int'(i_current_floor)) w_pend_cur = 1'b1;
        if (k >  int'(i_current_floor)) w_above    = 1'b1;
        if (k <  int'(i_current_floor)) w_below    = 1'b1;
      end
    end
  end

  // Next state, sweep direction and door timer; a fault overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir_up;
    w_timer_nxt = r_timer;
    w_clear_cur = 1'b0;
    if (w_fault) begin
      w_state_nxt = ST_ALARM;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pend_cur) begin
            w_state_nxt = ST_DOOR_OPEN;
            w_timer_nxt = '0;
            w_clear_cur = 1'b1;
          end else if (r_dir_up && w_above) begin
            w_state_nxt = ST_MOVE_UP;
          end else if (w_below) begin
            w_state_nxt = ST_MOVE_DOWN;
            w_dir_nxt   = 1'b0;
          end else if (w_above) begin
            w_state_nxt = ST_MOVE_UP;
            w_dir_nxt   = 1'b1;
          end
        end
        ST_MOVE_UP: begin
          if (w_pend_cur) begin
            w_state_nxt = ST_DOOR_OPEN;
            w_timer_nxt = '0;
            w_clear_cur = 1'b1;
          end else if (!w_above) begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_MOVE_DOWN: begin
          if (w_pend_cur) begin
            w_state_nxt = ST_DOOR_OPEN;
            w_timer_nxt = '0;
            w_clear_cur = 1'b1;
          end else if (!w_below) begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_DOOR_OPEN: begin
          if (w_hold) begin
            w_timer_nxt = '0;
          end else if (r_timer == LP_DOOR_LAST) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_timer_nxt = r_timer + pTIMER_BITS'(1);
          end
        end
        ST_ALARM: begin
          if (i_error_clear) w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Pending bitmap update; the stop-arrival clear beats a same-cycle request for that floor.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int k = 0; k < pFLOOR_COUNT; k++) begin
      if (i_req_valid && w_req_in_range && !w_hold && (k == int'(i_req_floor))) w_pending_nxt[k] = 1'b1;
      if (w_clear_cur && (k == int'(i_current_floor))) w_pending_nxt[k] = 1'b0;
    end
  end

  // State, direction, timer, bitmap and drop-pulse registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_dir_up   <= 1'b1;
      r_timer    <= '0;
      r_pending  <= '0;
      r_req_drop <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dir_up   <= w_dir_nxt;
      r_timer    <= w_timer_nxt;
      r_pending  <= w_pending_nxt;
      r_req_drop <= i_req_valid && !w_req_in_range;
    end
  end

  assign o_move_up   = (r_state == ST_MOVE_UP);
  assign o_move_down = (r_state == ST_MOVE_DOWN);
  assign o_open_door = (r_state == ST_DOOR_OPEN);
  assign o_alarm     = (r_state == ST_ALARM);
  assign o_dir_up    = r_dir_up;
  assign o_pending   = r_pending;
  assign o_req_drop  = r_req_drop;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl: a 16-floor instance driven by a simple car model, plus a 12-floor instance.
// Latency: inputs change on the falling edge and outputs are sampled there, half a cycle after each rising edge.
// Backpressure: none; each wait is bounded by a cycle budget and counts as a failed check when the budget runs out.
module tb_elevator_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld;
  logic [3:0]  req_floor;
  logic [3:0]  cur;
  logic        err_flag;
  logic        err_clr;
  logic        move_up, move_dn, door, alarm, dir_up, drop;
  logic [15:0] pending;

  logic        c_req_vld;
  logic [3:0]  c_req_floor;
  logic [3:0]  c_cur;
  logic        c_flag;
  logic        c_clr;
  logic        c_up, c_dn, c_door, c_alarm, c_dir, c_drop;
  logic [11:0] c_pending;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  stops[$];
  logic        prev_open = 1'b0;

  always #5 clk = ~clk;

  elevator_scan_ctrl dut (
    .i_clock(clk), .i_reset(rst), .i_req_valid(req_vld), .i_req_floor(req_floor),
    .i_current_floor(cur), .i_error_flag(err_flag), .i_error_clear(err_clr),
    .o_move_up(move_up), .o_move_down(move_dn), .o_open_door(door), .o_alarm(alarm),
    .o_dir_up(dir_up), .o_pending(pending), .o_req_drop(drop)
  );

  elevator_scan_ctrl #(.pFLOOR_COUNT(12)) dut12 (
    .i_clock(clk), .i_reset(rst), .i_req_valid(c_req_vld), .i_req_floor(c_req_floor),
    .i_current_floor(c_cur), .i_error_flag(c_flag), .i_error_clear(c_clr),
    .o_move_up(c_up), .o_move_down(c_dn), .o_open_door(c_door), .o_alarm(c_alarm),
    .o_dir_up(c_dir), .o_pending(c_pending), .o_req_drop(c_drop)
  );

  // One clock; then log door openings and move the car one floor per cycle of motor command.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (door && !prev_open) stops.push_back(cur);
    prev_open = door;
    if (move_up && cur < 4'd15) cur = cur + 4'd1;
    else if (move_dn && cur > 4'd0) cur = cur - 4'd1;
  endtask

  task automatic do_reset(input logic [3:0] start_floor);
    rst = 1'b1;
    req_vld = 1'b0; req_floor = '0; err_flag = 1'b0; err_clr = 1'b0;
    c_req_vld = 1'b0; c_req_floor = '0; c_cur = '0; c_flag = 1'b0; c_clr = 1'b0;
    cur = start_floor;
    step();
    step();
    rst = 1'b0;
    stops.delete();
    prev_open = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    int n = 0;
    while (!(pending == 16'h0 && !move_up && !move_dn && !door && !alarm) && n < budget) begin
      step();
      n++;
    end
    timed_out = (n >= budget);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_vld = 1'b0; req_floor = '0; err_flag = 1'b0; err_clr = 1'b0; cur = '0;
    c_req_vld = 1'b0; c_req_floor = '0; c_cur = '0; c_flag = 1'b0; c_clr = 1'b0;
    #1;
    checks++;
    if ({move_up, move_dn, door, alarm} !== 4'b0000) begin
      errors++; $display("FAIL reset_cmds: got %b, expected 0000", {move_up, move_dn, door, alarm});
    end
    checks++;
    if (pending !== 16'h0) begin
      errors++; $display("FAIL reset_pending: got %h, expected 0000", pending);
    end
    checks++;
    if (dir_up !== 1'b1 || drop !== 1'b0) begin
      errors++; $display("FAIL reset_dir_drop: got dir=%b drop=%b, expected dir=1 drop=0", dir_up, drop);
    end
    checks++;
    if ({c_up, c_dn, c_door, c_alarm, c_drop} !== 5'b0 || c_pending !== 12'h0 || c_dir !== 1'b1) begin
      errors++; $display("FAIL reset_dut12: got cmds=%b pend=%h dir=%b, expected 0/000/1",
                         {c_up, c_dn, c_door, c_alarm, c_drop}, c_pending, c_dir);
    end
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_door_at_floor();
    int n = 0;
    do_reset(4'd0);
    repeat (2) step();
    req_vld = 1'b1; req_floor = 4'd0;
    step();
    req_vld = 1'b0;
    checks++;
    if (pending !== 16'h0001 || door !== 1'b0) begin
      errors++; $display("FAIL door0_capture: got pend=%h door=%b, expected 0001/0", pending, door);
    end
    step();
    checks++;
    if (door !== 1'b1 || pending !== 16'h0) begin
      errors++; $display("FAIL door0_open: got door=%b pend=%h, expected 1/0000", door, pending);
    end
    while (door && n < 100) begin
      n++;
      step();
    end
    checks++;
    if (n !== 32) begin
      errors++; $display("FAIL door0_dwell: got %0d cycles open, expected 32", n);
    end
    checks++;
    if ({move_up, move_dn, door, alarm} !== 4'b0000) begin
      errors++; $display("FAIL door0_idle: got %b, expected 0000", {move_up, move_dn, door, alarm});
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    do_reset(4'd2);
    req_vld = 1'b1; req_floor = 4'd2;
    step();
    checks++;
    if (pending !== 16'h0004) begin
      errors++; $display("FAIL b2b_first: got pend=%h, expected 0004", pending);
    end
    step();
    req_vld = 1'b0;
    checks++;
    if (door !== 1'b1 || pending !== 16'h0) begin
      errors++; $display("FAIL b2b_clear_wins: got door=%b pend=%h, expected 1/0000", door, pending);
    end
    wait_idle(200, to);
    checks++;
    if (to) begin
      errors++; $display("FAIL b2b_timeout: got no idle within 200 cycles, expected idle");
    end
  endtask

  task automatic test_sweep_up();
    bit to;
    do_reset(4'd0);
    req_vld = 1'b1; req_floor = 4'd5;
    step();
    checks++;
    if (move_up !== 1'b0 || pending !== 16'h0020) begin
      errors++; $display("FAIL sweep_cap: got up=%b pend=%h, expected 0/0020", move_up, pending);
    end
    req_floor = 4'd2;
    step();
    checks++;
    if (move_up !== 1'b1) begin
      errors++; $display("FAIL sweep_latency: got up=%b, expected 1", move_up);
    end
    req_floor = 4'd5;
    step();
    req_vld = 1'b0;
    checks++;
    if (pending !== 16'h0024) begin
      errors++; $display("FAIL sweep_dup: got pend=%h, expected 0024", pending);
    end
    wait_idle(400, to);
    checks++;
    if (to || pending !== 16'h0 || dir_up !== 1'b1) begin
      errors++; $display("FAIL sweep_end: got to=%b pend=%h dir=%b, expected 0/0000/1", to, pending, dir_up);
    end
    checks++;
    if (stops.size() != 2) begin
      errors++; $display("FAIL sweep_stops: got %p, expected 2 then 5", stops);
    end else if (stops[0] !== 4'd2 || stops[1] !== 4'd5) begin
      errors++; $display("FAIL sweep_stops: got %p, expected 2 then 5", stops);
    end
  endtask

  task automatic test_look_reverse();
    bit to;
    do_reset(4'd6);
    req_vld = 1'b1; req_floor = 4'd6;
    step();
    req_vld = 1'b0;
    step();
    req_vld = 1'b1; req_floor = 4'd3;
    step();
    req_floor = 4'd9;
    step();
    req_vld = 1'b0;
    checks++;
    if (pending !== 16'h0208 || door !== 1'b1 || dir_up !== 1'b1) begin
      errors++; $display("FAIL look_queued: got pend=%h door=%b dir=%b, expected 0208/1/1", pending, door, dir_up);
    end
    wait_idle(400, to);
    checks++;
    if (to || dir_up !== 1'b0) begin
      errors++; $display("FAIL look_dir: got to=%b dir=%b, expected 0/0", to, dir_up);
    end
    checks++;
    if (stops.size() != 3) begin
      errors++; $display("FAIL look_stops: got %p, expected 6, 9, 3", stops);
    end else if (stops[0] !== 4'd6 || stops[1] !== 4'd9 || stops[2] !== 4'd3) begin
      errors++; $display("FAIL look_stops: got %p, expected 6, 9, 3", stops);
    end
  endtask

  task automatic test_door_hold();
    int n = 0;
    do_reset(4'd4);
    req_vld = 1'b1; req_floor = 4'd4;
    step();
    req_vld = 1'b0;
    step();
    repeat (19) step();
    checks++;
    if (door !== 1'b1) begin
      errors++; $display("FAIL hold_pre: got door=%b, expected 1", door);
    end
    req_vld = 1'b1; req_floor = 4'd4;
    step();
    req_vld = 1'b0;
    checks++;
    if (pending !== 16'h0) begin
      errors++; $display("FAIL hold_pending: got pend=%h, expected 0000", pending);
    end
    while (door && n < 100) begin
      n++;
      step();
    end
    checks++;
    if (n !== 32) begin
      errors++; $display("FAIL hold_dwell: got %0d more cycles open, expected 32", n);
    end
  endtask

  task automatic test_alarm();
    bit to;
    do_reset(4'd0);
    req_vld = 1'b1; req_floor = 4'd9;
    step();
    req_vld = 1'b0;
    step();
    checks++;
    if (move_up !== 1'b1) begin
      errors++; $display("FAIL alarm_pre: got up=%b, expected 1", move_up);
    end
    step();
    err_flag = 1'b1;
    step();
    checks++;
    if (alarm !== 1'b1 || move_up !== 1'b0 || pending !== 16'h0200) begin
      errors++; $display("FAIL alarm_enter: got al=%b up=%b pend=%h, expected 1/0/0200", alarm, move_up, pending);
    end
    err_clr = 1'b1;
    req_vld = 1'b1; req_floor = 4'd12;
    step();
    req_vld = 1'b0;
    checks++;
    if (alarm !== 1'b1 || pending !== 16'h1200) begin
      errors++; $display("FAIL alarm_flag_clr: got al=%b pend=%h, expected 1/1200", alarm, pending);
    end
    err_flag = 1'b0;
    step();
    err_clr = 1'b0;
    checks++;
    if ({move_up, move_dn, door, alarm} !== 4'b0000) begin
      errors++; $display("FAIL alarm_exit: got %b, expected 0000", {move_up, move_dn, door, alarm});
    end
    wait_idle(500, to);
    checks++;
    if (to) begin
      errors++; $display("FAIL alarm_resume_timeout: got no idle within 500 cycles, expected idle");
    end
    checks++;
    if (stops.size() != 2) begin
      errors++; $display("FAIL alarm_stops: got %p, expected 9 then 12", stops);
    end else if (stops[0] !== 4'd9 || stops[1] !== 4'd12) begin
      errors++; $display("FAIL alarm_stops: got %p, expected 9 then 12", stops);
    end
  endtask

  task automatic test_range();
    do_reset(4'd0);
    c_req_vld = 1'b1; c_req_floor = 4'd11;
    step();
    checks++;
    if (c_pending !== 12'h800 || c_drop !== 1'b0) begin
      errors++; $display("FAIL range_top_floor: got pend=%h drop=%b, expected 800/0", c_pending, c_drop);
    end
    c_req_floor = 4'd15;
    step();
    c_req_vld = 1'b0;
    checks++;
    if (c_drop !== 1'b1 || c_pending !== 12'h800) begin
      errors++; $display("FAIL range_drop: got drop=%b pend=%h, expected 1/800", c_drop, c_pending);
    end
    step();
    checks++;
    if (c_drop !== 1'b0) begin
      errors++; $display("FAIL range_drop_pulse: got drop=%b, expected 0", c_drop);
    end
    c_cur = 4'd13;
    step();
    checks++;
    if (c_alarm !== 1'b1 || c_up !== 1'b0 || c_pending !== 12'h800) begin
      errors++; $display("FAIL range_cur_fault: got al=%b up=%b pend=%h, expected 1/0/800", c_alarm, c_up, c_pending);
    end
    c_cur = 4'd5;
    c_clr = 1'b1;
    step();
    c_clr = 1'b0;
    checks++;
    if (c_alarm !== 1'b0) begin
      errors++; $display("FAIL range_cur_recover: got al=%b, expected 0", c_alarm);
    end
  endtask

  task automatic test_async_reset();
    do_reset(4'd8);
    req_vld = 1'b1; req_floor = 4'd2;
    step();
    req_vld = 1'b0;
    step();
    step();
    checks++;
    if (move_dn !== 1'b1 || dir_up !== 1'b0) begin
      errors++; $display("FAIL async_pre: got dn=%b dir=%b, expected 1/0", move_dn, dir_up);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (move_dn !== 1'b0 || dir_up !== 1'b1 || pending !== 16'h0) begin
      errors++; $display("FAIL async_reset: got dn=%b dir=%b pend=%h, expected 0/1/0000", move_dn, dir_up, pending);
    end
    step();
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({move_up, move_dn, door, alarm} !== 4'b0000 || pending !== 16'h0) begin
      errors++; $display("FAIL async_lost: got cmds=%b pend=%h, expected 0000/0000",
                         {move_up, move_dn, door, alarm}, pending);
    end
  endtask

  initial begin
    test_reset();
    test_door_at_floor();
    test_back_to_back();
    test_sweep_up();
    test_look_reverse();
    test_door_hold();
    test_alarm();
    test_range();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish by time 300000, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
- Next-generation elevator core that replaces the FIFO-ordered request path with a per-floor pending-request bitmap and LOOK (directional sweep) scheduling.
- Integrates the move/door/alarm state machine and the door dwell timer in one block.
- Generic in floor count and door dwell time.
- Sits between the hall/car call inputs plus the floor sensor, and the motor/door/alarm drivers.

Parameters:
- pFLOOR_COUNT, 16, number of served floors (2..2^pFLOOR_WIDTH).
- pFLOOR_WIDTH, 4, width of floor indices.
- pDOOR_CYCLES, 32, clock cycles the door stays open per stop (>=2).
- pTIMER_BITS, 6, door timer width; must hold pDOOR_CYCLES-1.

Ports:
- i_clock  in  1  single clock; all state updates on its rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_req_valid  in  1  request strobe, one request per cycle.
- i_req_floor  in  pFLOOR_WIDTH  requested floor, sampled when i_req_valid=1.
- i_current_floor  in  pFLOOR_WIDTH  floor sensor value, synchronous to i_clock.
- i_error_flag  in  1  fault input.
- i_error_clear  in  1  fault acknowledge.
- o_move_up  out  1  motor up command.
- o_move_down  out  1  motor down command.
- o_open_door  out  1  door open command.
- o_alarm  out  1  alarm active.
- o_dir_up  out  1  current sweep direction (1 = up).
- o_pending  out  pFLOOR_COUNT  pending-request bitmap; bit k = floor k.
- o_req_drop  out  1  one-cycle pulse, registered: the request was out of range (i_req_floor >= pFLOOR_COUNT) and was discarded.

Behaviour:
- Reset:
  - state = IDLE, o_pending = 0, o_dir_up = 1, door timer = 0.
  - o_move_up, o_move_down, o_open_door, o_alarm, o_req_drop = 0.
- Outputs are a registered/Moore decode of state:
  - MOVE_UP -> o_move_up.
  - MOVE_DOWN -> o_move_down.
  - DOOR_OPEN -> o_open_door.
  - ALARM -> o_alarm.
  - At most one of these four is ever high.
- Request capture:
  - A valid in-range request on cycle N sets its o_pending bit at the edge ending cycle N.
  - Setting an already-set bit has no effect; the bitmap cannot overflow.
- States are IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, ALARM. "above" = any pending bit > i_current_floor; "below" = any pending bit < i_current_floor.
- IDLE:
  - If pending[cur] -> DOOR_OPEN.
  - Else if o_dir_up and above -> MOVE_UP.
  - Else if below -> MOVE_DOWN, with o_dir_up := 0.
  - Else if above -> MOVE_UP, with o_dir_up := 1.
  - Else stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - When pending[cur] = 1 -> DOOR_OPEN.
  - When no pending bit remains in the travel direction -> IDLE.
  - Otherwise hold.
- DOOR_OPEN entry: pending[cur] is cleared and the timer loads 0.
  - The timer increments every cycle.
  - At count pDOOR_CYCLES-1 -> IDLE. o_open_door is therefore high for exactly pDOOR_CYCLES cycles.
- Same-floor request while in DOOR_OPEN: the bit is not set and the timer restarts from 0 (door hold).
- Request capture and DOOR_OPEN-entry clear of the same bit in the same cycle: the clear wins.
- Latency:
  - Request at cycle N from IDLE with the car elsewhere: pending visible at N+1, state change at the N+1 edge, o_move_* high at N+2.
  - Request for the current floor from IDLE: o_open_door high at N+2.
- Fault handling:
  - i_error_flag=1 in any state -> ALARM at the next edge. This has priority over every other transition.
  - The door timer is reset on entering ALARM.
  - o_pending is retained and requests are still captured during ALARM.
- ALARM:
  - Exits to IDLE only when i_error_clear=1 and i_error_flag=0 on the same cycle.
  - Flag and clear both high on the same cycle: stay in ALARM.
- i_current_floor >= pFLOOR_COUNT:
  - Treated as a fault: behaves exactly as i_error_flag=1.
- Asynchronous reset asserted mid-move or mid-door:
  - All outputs drop to their reset values immediately (no clock edge needed).
  - The pending requests are lost.

Test Plan:
- Reset, cur=0, request floor 0 at cycle 5 -> o_open_door high cycles 7..(7+pDOOR_CYCLES-1), o_pending[0] cleared at the cycle-6 edge.
- cur=0, requests 5 then 2 -> o_move_up; stops at floor 2 first (door for 32 cycles), then 5; o_pending=0 at end; o_dir_up stays 1.
- cur=6, o_dir_up=1, requests 3 and 9 -> serves 9 first, then reverses (o_dir_up=0) and serves 3.
- Door open at floor 4 for 20 cycles, request floor 4 -> door stays open 32 more cycles from the request; o_pending[4] stays 0.
- While moving up, i_error_flag=1 -> next cycle o_alarm=1, o_move_up=0, pending kept.
  - Flag and clear together -> stays in ALARM.
  - Clear alone -> IDLE, and resumes servicing the pending requests.
- Request floor 15 with pFLOOR_COUNT=12 -> o_req_drop pulses 1 cycle, o_pending unchanged.
- i_current_floor=13 with pFLOOR_COUNT=12 -> ALARM.
